// File: rtl/rwc_pkg.sv
// rwc_pkg: shared types and constants for the RWC responder.
//   rwc_state_e        - responder FSM state encoding (IDLE=0 .. DONE=7)
//   DefDataW/DefAddrW  - default challenge word and BRAM address widths
//   rwc_total_latency  - edges from the IDLE sampling edge to available
package rwc_pkg;

   localparam int unsigned DefDataW = 32;
   localparam int unsigned DefAddrW = 10;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPreset   = 3'd1,
      StSettle   = 3'd2,
      StCollideW = 3'd3,
      StWaitW    = 3'd4,
      StCollideC = 3'd5,
      StWaitC    = 3'd6,
      StDone     = 3'd7
   } rwc_state_e;

   function automatic int unsigned rwc_total_latency(input int unsigned settle_cycles,
                                                     input int unsigned read_latency);
      return 3 + settle_cycles + 2 * read_latency;
   endfunction

endpackage

// File: rtl/rwc_responder_if.sv
// rwc_responder_if: challenge/response handshake plus the true-dual-port BRAM strobes.
//   gen_enable/cha_data/cha_addr   - challenge request from the initiator
//   available/rsp_write/rsp_clean  - collision read-backs returned to the initiator
//   busy                           - run in progress
//   ram_a_*                        - BRAM port A (write side)
//   ram_b_*                        - BRAM port B (read side)
// slave modport = responder, master modport = initiator + RAM side.
interface rwc_responder_if #(
   parameter int unsigned DATA_W = rwc_pkg::DefDataW,
   parameter int unsigned ADDR_W = rwc_pkg::DefAddrW
) ();

   logic              gen_enable;
   logic [31:0]       cha_data;
   logic [31:0]       cha_addr;
   logic              available;
   logic [DATA_W-1:0] rsp_write;
   logic [DATA_W-1:0] rsp_clean;
   logic              busy;
   logic              ram_a_en;
   logic              ram_a_we;
   logic [ADDR_W-1:0] ram_a_addr;
   logic [DATA_W-1:0] ram_a_din;
   logic              ram_b_en;
   logic [ADDR_W-1:0] ram_b_addr;
   logic [DATA_W-1:0] ram_b_dout;

   modport slave (
      input  gen_enable, cha_data, cha_addr, ram_b_dout,
      output available, rsp_write, rsp_clean, busy,
             ram_a_en, ram_a_we, ram_a_addr, ram_a_din, ram_b_en, ram_b_addr
   );

   modport master (
      output gen_enable, cha_data, cha_addr, ram_b_dout,
      input  available, rsp_write, rsp_clean, busy,
             ram_a_en, ram_a_we, ram_a_addr, ram_a_din, ram_b_en, ram_b_addr
   );

endinterface

// File: rtl/rwc_delay_cnt.sv
// rwc_delay_cnt: loadable down-counter timing the SETTLE and WAIT states.
//   clk, rst    - clock, asynchronous active-high reset
//   load_i      - load load_val_i this edge (takes priority over counting)
//   load_val_i  - number of cycles the next state lasts (0 for untimed states)
//   done_o      - high during the last cycle of the timed interval
module rwc_delay_cnt #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A load of N gives N cycles; the last one sees the count at 1.
   assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rwc_responder.sv
// rwc_responder: responder end of the read-write-collision challenge.
// Latches a challenge, presets the BRAM word to ~data, then twice makes port A write and
// port B read the same address in one cycle (first with data, then with zeros) and returns
// both port-B read-backs.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - rwc_responder_if.slave (challenge, response, BRAM port A/B)
module rwc_responder
   import rwc_pkg::*;
#(
   parameter int unsigned DATA_W        = DefDataW,
   parameter int unsigned ADDR_W        = DefAddrW,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned READ_LATENCY  = 2
) (
   input  logic           clk,
   input  logic           rst,
   rwc_responder_if.slave bus
);

   localparam int unsigned CntMax = (SETTLE_CYCLES > READ_LATENCY) ? SETTLE_CYCLES
                                                                   : READ_LATENCY;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   rwc_state_e        state_q;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] addr_q;
   logic              available_q, busy_q;
   logic [DATA_W-1:0] rsp_write_q, rsp_clean_q;
   logic              ram_a_en_q, ram_a_we_q, ram_b_en_q;
   logic [ADDR_W-1:0] ram_a_addr_q, ram_b_addr_q;
   logic [DATA_W-1:0] ram_a_din_q;

   logic              cnt_load, cnt_done;
   logic [CntW-1:0]   cnt_val;

   logic              unused_addr_hi;
   assign unused_addr_hi = ^bus.cha_addr[31:ADDR_W];

   // Load the counter on every state change: cycle count for timed states, 0 otherwise.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      unique case (state_q)
         StIdle:     cnt_load = bus.gen_enable;
         StPreset: begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(SETTLE_CYCLES);
         end
         StSettle, StWaitW, StWaitC: cnt_load = cnt_done;
         StCollideW, StCollideC: begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(READ_LATENCY);
         end
         StDone:     cnt_load = ~bus.gen_enable;
         default:    ;
      endcase
   end

   rwc_delay_cnt #(
      .CNT_W (CntW)
   ) u_delay_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .done_o     (cnt_done)
   );

   // Strobes are registered: they are set on the edge that enters the strobing state, so
   // they are high for exactly that state's cycle and return to 0 (addresses too) after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         data_q       <= '0;
         addr_q       <= '0;
         available_q  <= 1'b0;
         busy_q       <= 1'b0;
         rsp_write_q  <= '0;
         rsp_clean_q  <= '0;
         ram_a_en_q   <= 1'b0;
         ram_a_we_q   <= 1'b0;
         ram_a_addr_q <= '0;
         ram_a_din_q  <= '0;
         ram_b_en_q   <= 1'b0;
         ram_b_addr_q <= '0;
      end else begin
         ram_a_en_q   <= 1'b0;
         ram_a_we_q   <= 1'b0;
         ram_a_addr_q <= '0;
         ram_a_din_q  <= '0;
         ram_b_en_q   <= 1'b0;
         ram_b_addr_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (bus.gen_enable) begin
                  data_q       <= bus.cha_data[DATA_W-1:0];
                  addr_q       <= bus.cha_addr[ADDR_W-1:0];
                  busy_q       <= 1'b1;
                  ram_a_en_q   <= 1'b1;
                  ram_a_we_q   <= 1'b1;
                  ram_a_addr_q <= bus.cha_addr[ADDR_W-1:0];
                  ram_a_din_q  <= ~bus.cha_data[DATA_W-1:0];
                  state_q      <= StPreset;
               end
            end
            StPreset: state_q <= StSettle;
            StSettle: begin
               if (cnt_done) begin
                  ram_a_en_q   <= 1'b1;
                  ram_a_we_q   <= 1'b1;
                  ram_a_addr_q <= addr_q;
                  ram_a_din_q  <= data_q;
                  ram_b_en_q   <= 1'b1;
                  ram_b_addr_q <= addr_q;
                  state_q      <= StCollideW;
               end
            end
            StCollideW: state_q <= StWaitW;
            StWaitW: begin
               if (cnt_done) begin
                  rsp_write_q  <= bus.ram_b_dout;
                  ram_a_en_q   <= 1'b1;
                  ram_a_we_q   <= 1'b1;
                  ram_a_addr_q <= addr_q;
                  ram_b_en_q   <= 1'b1;
                  ram_b_addr_q <= addr_q;
                  state_q      <= StCollideC;
               end
            end
            StCollideC: state_q <= StWaitC;
            StWaitC: begin
               if (cnt_done) begin
                  rsp_clean_q <= bus.ram_b_dout;
                  busy_q      <= 1'b0;
                  available_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (!bus.gen_enable) begin
                  available_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.available  = available_q;
   assign bus.busy       = busy_q;
   assign bus.rsp_write  = rsp_write_q;
   assign bus.rsp_clean  = rsp_clean_q;
   assign bus.ram_a_en   = ram_a_en_q;
   assign bus.ram_a_we   = ram_a_we_q;
   assign bus.ram_a_addr = ram_a_addr_q;
   assign bus.ram_a_din  = ram_a_din_q;
   assign bus.ram_b_en   = ram_b_en_q;
   assign bus.ram_b_addr = ram_b_addr_q;

endmodule

// File: tb/tb_rwc_responder.sv
// tb_rwc_responder: directed bench for rwc_responder against a 2-cycle-latency
// true-dual-port RAM model switchable between read-first and write-first collisions.
module tb_rwc_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rwc_responder_if #(.DATA_W(32), .ADDR_W(10)) bus ();

   rwc_responder #(
      .DATA_W        (32),
      .ADDR_W        (10),
      .SETTLE_CYCLES (4),
      .READ_LATENCY  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   // RAM model
   logic [31:0] mem [1024];
   logic [31:0] pipe1 = '0;
   logic [31:0] dout  = '0;
   logic        write_first = 1'b0;
   logic [31:0] wlog_d [$];
   logic [9:0]  wlog_a [$];
   int          b_reads = 0;

   function automatic logic [31:0] rd_val();
      if (write_first && bus.ram_a_en && bus.ram_a_we && bus.ram_a_addr == bus.ram_b_addr)
         return bus.ram_a_din;
      return mem[bus.ram_b_addr];
   endfunction

   always @(posedge clk) begin
      if (bus.ram_b_en) begin
         pipe1   <= rd_val();
         b_reads <= b_reads + 1;
      end
      dout <= pipe1;
      if (bus.ram_a_en && bus.ram_a_we) begin
         mem[bus.ram_a_addr] <= bus.ram_a_din;
         wlog_d.push_back(bus.ram_a_din);
         wlog_a.push_back(bus.ram_a_addr);
      end
   end

   assign bus.ram_b_dout = dout;

   // Address monitor: latched address while enabled, 0 otherwise.
   logic [9:0] exp_addr = '0;
   int         addr_err = 0;
   always @(negedge clk) begin
      if ((bus.ram_a_en && bus.ram_a_addr !== exp_addr) || (!bus.ram_a_en && bus.ram_a_addr !== 10'd0)
          || (bus.ram_b_en && bus.ram_b_addr !== exp_addr)
          || (!bus.ram_b_en && bus.ram_b_addr !== 10'd0))
         addr_err <= addr_err + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_avail(output int edges);
      edges = 0;
      while (!bus.available && edges < 40) begin
         step();
         edges++;
      end
   endtask

   task automatic start_run(input logic [31:0] d, input logic [31:0] a);
      bus.cha_data   = d;
      bus.cha_addr   = a;
      bus.gen_enable = 1'b1;
      step();
   endtask

   int n, w0, b0;

   initial begin
      bus.gen_enable = 1'b0;
      bus.cha_data   = '0;
      bus.cha_addr   = '0;
      #3;
      chk("rst_available", {31'd0, bus.available}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_strobes", {29'd0, bus.ram_a_en, bus.ram_a_we, bus.ram_b_en}, 32'd0);
      chk("rst_rsp_write", bus.rsp_write, 32'd0);
      chk("rst_rsp_clean", bus.rsp_clean, 32'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // 1: read-first, all-ones at address 0
      write_first = 1'b0;
      exp_addr    = 10'h000;
      w0          = wlog_d.size();
      b0          = b_reads;
      start_run(32'hFFFF_FFFF, 32'h0);
      chk("t1_busy", {31'd0, bus.busy}, 32'd1);
      chk("t1_preset_din", bus.ram_a_din, 32'h0000_0000);
      wait_avail(n);
      chk("t1_latency", n, 11);
      chk("t1_rsp_write", bus.rsp_write, 32'h0000_0000);
      chk("t1_rsp_clean", bus.rsp_clean, 32'hFFFF_FFFF);
      chk("t1_busy_done", {31'd0, bus.busy}, 32'd0);
      chk("t1_nwrites", wlog_d.size() - w0, 3);
      chk("t1_nreads", b_reads - b0, 2);
      if (wlog_d.size() - w0 == 3) begin
         chk("t1_w0", wlog_d[w0], 32'h0000_0000);
         chk("t1_w1", wlog_d[w0+1], 32'hFFFF_FFFF);
         chk("t1_w2", wlog_d[w0+2], 32'h0000_0000);
         chk("t1_waddr", {22'd0, wlog_a[w0] | wlog_a[w0+1] | wlog_a[w0+2]}, 32'd0);
      end
      step();
      chk("t1_done_hold", {31'd0, bus.available}, 32'd1);
      bus.gen_enable = 1'b0;
      step();
      chk("t1_avail_drop", {31'd0, bus.available}, 32'd0);
      step();

      // 2: write-first, top address
      write_first = 1'b1;
      exp_addr    = 10'h3FF;
      start_run(32'hA5A5_1234, 32'h0000_03FF);
      wait_avail(n);
      chk("t2_latency", n, 11);
      chk("t2_rsp_write", bus.rsp_write, 32'hA5A5_1234);
      chk("t2_rsp_clean", bus.rsp_clean, 32'h0000_0000);
      bus.gen_enable = 1'b0;
      step();
      step();

      // 3: only low address bits used; inputs changed after sampling are ignored
      exp_addr = 10'h005;
      w0       = wlog_d.size();
      start_run(32'h1234_5678, 32'hFFFF_FC05);
      bus.cha_data = 32'hDEAD_BEEF;
      bus.cha_addr = 32'h0000_0010;
      wait_avail(n);
      chk("t3_rsp_write", bus.rsp_write, 32'h1234_5678);
      chk("t3_rsp_clean", bus.rsp_clean, 32'h0000_0000);
      chk("t3_preset", wlog_d[w0], 32'hEDCB_A987);
      chk("t3_addr", {22'd0, wlog_a[w0]}, 32'h005);
      bus.gen_enable = 1'b0;
      step();
      step();

      // 4: gen_enable dropped during SETTLE
      exp_addr = 10'h022;
      start_run(32'h0F0F_0F0F, 32'h0000_0022);
      step();
      step();
      bus.gen_enable = 1'b0;
      wait_avail(n);
      chk("t4_latency", n + 2, 11);
      chk("t4_rsp_write", bus.rsp_write, 32'h0F0F_0F0F);
      step();
      chk("t4_avail_1cyc", {31'd0, bus.available}, 32'd0);
      chk("t4_busy_after", {31'd0, bus.busy}, 32'd0);
      step();

      // 5: reset mid WAIT_W, then a clean rerun of test 1
      write_first = 1'b0;
      exp_addr    = 10'h000;
      start_run(32'hFFFF_FFFF, 32'h0);
      repeat (6) step();
      chk("t5_in_wait", {30'd0, bus.busy, bus.ram_b_en}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_strobes", {29'd0, bus.ram_a_en, bus.ram_a_we, bus.ram_b_en}, 32'd0);
      chk("t5_rst_busy_avail", {30'd0, bus.busy, bus.available}, 32'd0);
      chk("t5_rst_rsp_write", bus.rsp_write, 32'd0);
      chk("t5_rst_rsp_clean", bus.rsp_clean, 32'd0);
      bus.gen_enable = 1'b0;
      step();
      rst = 1'b0;
      step();
      start_run(32'hFFFF_FFFF, 32'h0);
      wait_avail(n);
      chk("t5_latency", n, 11);
      chk("t5_rsp_write", bus.rsp_write, 32'h0000_0000);
      chk("t5_rsp_clean", bus.rsp_clean, 32'hFFFF_FFFF);
      bus.gen_enable = 1'b0;
      step();
      step();

      // 6: back-to-back runs with one idle cycle
      write_first = 1'b1;
      exp_addr    = 10'h007;
      start_run(32'h0000_0001, 32'h0000_0007);
      wait_avail(n);
      chk("t6a_rsp_write", bus.rsp_write, 32'h0000_0001);
      chk("t6a_rsp_clean", bus.rsp_clean, 32'h0000_0000);
      bus.gen_enable = 1'b0;
      step();
      chk("t6_idle_avail", {31'd0, bus.available}, 32'd0);
      write_first = 1'b0;
      start_run(32'h8000_0000, 32'h0000_0007);
      chk("t6b_busy", {31'd0, bus.busy}, 32'd1);
      repeat (3) step();
      chk("t6b_hold_write", bus.rsp_write, 32'h0000_0001);
      chk("t6b_hold_clean", bus.rsp_clean, 32'h0000_0000);
      wait_avail(n);
      chk("t6b_latency", n + 3, 11);
      chk("t6b_rsp_write", bus.rsp_write, 32'h7FFF_FFFF);
      chk("t6b_rsp_clean", bus.rsp_clean, 32'h8000_0000);
      bus.gen_enable = 1'b0;
      step();

      chk("addr_monitor", addr_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
